// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline latch/PC enable and flush sequencer with a RUN/DRAIN/HALTED halt FSM.
// Optional performance counters are enabled by defining PIPECTL_PERF_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_W = 5
`ifdef PIPECTL_PERF_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req,
  input  logic             dREN_ex,
  input  logic [REG_W-1:0] regDst_ex,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             usesRt_id,
  input  logic             brtaken_ex,
  input  logic             jr_ex,
  input  logic             jump_id,
  input  logic             halt_ex,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halt
`ifdef PIPECTL_PERF_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic mem_stall;
  logic redirect;
  logic load_use;

  assign mem_stall = dmem_req & ~dhit;
  assign redirect  = brtaken_ex | jr_ex;
  // Writes to $zero are discarded, so a load targeting r0 never creates a hazard.
  assign load_use  = dREN_ex & (regDst_ex != '0) &
                     ((regDst_ex == rs_id) | (usesRt_id & (regDst_ex == rt_id)));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Advance class first, then the modifiers that only matter when ID/EX moves.
  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    halt        = 1'b0;
    case (state_q)
      RUN: begin
        if (!mem_stall) begin
          if (dmem_req) begin
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else if (ihit) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
          end else begin
            exmem_en    = 1'b1;
            exmem_flush = 1'b1;
            memwb_en    = 1'b1;
          end
        end
        if (idex_en) begin
          if (halt_ex) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pc_en      = 1'b0;
            state_d    = DRAIN;
          end else if (redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pc_en      = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b1;
          end else if (jump_id) begin
            ifid_flush = 1'b1;
          end
        end
      end
      DRAIN: begin
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = ~mem_stall;
        memwb_en   = ~mem_stall;
        if (halt_wb) state_d = HALTED;
      end
      HALTED: begin
        halt = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    // Outputs read as zero for as long as reset is held.
    if (!nRST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      halt        = 1'b0;
    end
  end

`ifdef PIPECTL_PERF_EN
  // Counters wrap naturally and stop advancing once the core is halted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state_q != HALTED) begin
      cyc_cnt <= cyc_cnt + CNT_W'(1);
      if ((state_q == RUN) && !pc_en) stall_cnt <= stall_cnt + CNT_W'(1);
      if (idex_flush)                 flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. Each cycle it produces enable and flush strobes from the cache hits, load-use hazards, taken branches and jumps, and halt. The execute stage's flush/ihit latch controls are driven from here. Halt is handled by a small FSM that drains older instructions and then freezes the core.

Parameters:
REG_W, 5, register index width (regbit_t)
CNT_W, 32, width of the performance counters (optional feature only)

Ports:
CLK  in  1  clock, all state on rising edge
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction fetch completed this cycle
dhit  in  1  data access in MEM completed this cycle
dmem_req  in  1  MEM-stage instruction is a load or store (dREN|dWEN of EX/MEM)
dREN_ex  in  1  EX-stage instruction is a load
regDst_ex  in  REG_W  EX-stage destination register
rs_id  in  REG_W  ID-stage rs
rt_id  in  REG_W  ID-stage rt
usesRt_id  in  1  ID instruction reads rt
brtaken_ex  in  1  EX branch resolved taken (beq/bne using equal)
jr_ex  in  1  EX instruction is jr
jump_id  in  1  ID instruction is j/jal
halt_ex  in  1  EX instruction is halt
halt_wb  in  1  MEM/WB latch holds halt
pc_en  out  1  PC update enable
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
ifid_flush, idex_flush, exmem_flush  out  1 each  latch loads a bubble (valid only with the matching enable)
halt  out  1  core halted, sticky

Behaviour:
- Reset (nRST=0, async): state=RUN; all outputs 0.
- FSM states: RUN, DRAIN, HALTED. Outputs are combinational from state and inputs; only the state is registered.
- RUN, advance classes in priority order:
  - dmem_req & !dhit: freeze. All enables and pc_en are 0.
  - dmem_req & dhit: idex_en=exmem_en=memwb_en=1, ifid_en=1 with ifid_flush=1, pc_en=0. The fetch is not complete, so a bubble enters ID.
  - !dmem_req & ihit: all enables=1, pc_en=1.
  - !dmem_req & !ihit: memwb_en=exmem_en=1, exmem_flush=1, ifid_en=idex_en=0, pc_en=0. EX is held and a bubble goes to MEM.
- The following modifiers apply only when idex_en=1:
  - Redirect, when brtaken_ex|jr_ex: ifid_flush=1, idex_flush=1, pc_en=1. Redirect overrides load-use and jump.
  - Load-use, when dREN_ex & regDst_ex!=0 & (regDst_ex==rs_id | (usesRt_id & regDst_ex==rt_id)): pc_en=0, ifid_en=0, idex_flush=1. This inserts exactly one bubble, and the hazard clears next cycle because the load leaves EX.
  - Jump, when jump_id and there is no redirect or load-use: ifid_flush=1. pc_en follows the advance class.
- halt_ex in RUN with idex_en=1: next state is DRAIN. In the same cycle ifid_flush=idex_flush=1 and pc_en=0.
- DRAIN:
  - pc_en=0 and ifid_en=idex_en=1 with both flushes=1.
  - exmem_en and memwb_en follow the dmem_req/dhit rules.
  - halt_wb=1 leads to HALTED.
- HALTED: every enable and flush is 0, halt=1. The FSM leaves this state only on reset.
- Simultaneous halt_ex and brtaken_ex cannot occur (halt is not a branch); halt takes priority if it does.
- Reset asserted mid-stall or mid-drain forces RUN immediately, with outputs 0 while nRST=0.
- regDst_ex==0 never raises load-use, because writes to $zero are ignored.

Optional Feature:
PIPECTL_PERF_EN. When defined, adds three outputs of CNT_W bits each: cyc_cnt, stall_cnt and flush_cnt.
- cyc_cnt increments every cycle in RUN or DRAIN.
- stall_cnt increments on any RUN cycle with pc_en=0.
- flush_cnt increments on any cycle with idex_flush=1.
- All three reset to 0, wrap modulo 2^CNT_W, and freeze in HALTED.
When undefined, these ports and the counter logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then release with ihit=1 and no hazards: all enables=1, pc_en=1, flushes=0, halt=0.
- dREN_ex=1, regDst_ex=8, rs_id=8, ihit=1: pc_en=0, ifid_en=0, idex_flush=1 for one cycle. Next cycle (dREN_ex=0): full advance.
- dmem_req=1, dhit=0 for 3 cycles, then dhit=1: 3 cycles with all enables 0. Then idex/exmem/memwb_en=1, ifid_flush=1, pc_en=0.
- brtaken_ex=1 with the load-use condition also true, ihit=1: ifid_flush=idex_flush=1, pc_en=1, ifid_en=1. Redirect wins.
- halt_ex=1 with ihit=1, then halt_wb=1 two cycles later: DRAIN for 2 cycles with pc_en=0, then halt=1 and all enables 0 held for 10 cycles. nRST pulse returns all outputs to 0.
- With PIPECTL_PERF_EN and CNT_W=4: 17 stall cycles leave stall_cnt=1 (wrap).
